// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions for the burst responder.
// Direction encoding, responder state encoding, default burst length.
package mem_if_pkg;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam int DEF_BURST_LEN = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ADDR  = 3'd1,
    ST_RD_BURST = 3'd2,
    ST_WR_BURST = 3'd3,
    ST_RECOVER  = 3'd4
  } resp_state_t;

endpackage

// File: rtl/mem_sp_ram.sv
// Single-port synchronous RAM backing the burst responder.
// One write port, registered read (1-cycle latency), contents not reset.
module mem_sp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_Clk,
  input  logic                  i_We,
  input  logic [ADDR_WIDTH-1:0] i_Addr,
  input  logic [DATA_WIDTH-1:0] i_Data,
  output logic [DATA_WIDTH-1:0] o_Data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port plus registered read of the presented address
  always_ff @(posedge i_Clk) begin
    if (i_We) begin
      mem[i_Addr] <= i_Data;
    end
    o_Data <= mem[i_Addr];
  end

endmodule

// File: rtl/mem_burst_responder.sv
// Burst responder serving fixed-length wrapping bursts from on-chip RAM.
// Optional random stall injection: define MEM_RESPONDER_STALL_EN.
module mem_burst_responder
  import mem_if_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 22,
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int BURST_LEN      = DEF_BURST_LEN
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_MEM_Valid,
  input  logic [ADDRESS_WIDTH-1:0] i_MEM_Address,
  input  logic                     i_MEM_Read_Write_n,
  input  logic [DATA_WIDTH-1:0]    i_MEM_Data,
  output logic                     o_MEM_Data_Read,
  output logic [DATA_WIDTH-1:0]    o_MEM_Data,
  output logic                     o_MEM_Data_Valid,
  output logic                     o_MEM_Last,
  output logic                     o_Busy,
  output logic                     o_Error
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  resp_state_t              state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [RAM_ADDR_WIDTH-1:0] base_q, base_d;
  logic                     err_q, err_d;
  logic                     stall;
  logic                     in_burst;

  logic                      ram_we;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]     ram_q;

  // Low CW bits wrap inside the aligned block, no carry upward
  function automatic logic [RAM_ADDR_WIDTH-1:0] beat_addr(
    input logic [RAM_ADDR_WIDTH-1:0] b,
    input logic [CW-1:0]             k
  );
    beat_addr = b;
    beat_addr[CW-1:0] = b[CW-1:0] + k;
  endfunction

  if (ADDRESS_WIDTH > RAM_ADDR_WIDTH) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi =
      ^i_MEM_Address[ADDRESS_WIDTH-1:RAM_ADDR_WIDTH];
  end

  assign in_burst = (state_q == ST_WR_BURST) ||
                    (state_q == ST_RD_BURST);

`ifdef MEM_RESPONDER_STALL_EN
  logic [7:0] lfsr_q;
  logic [1:0] scnt_q;

  assign stall = in_burst && lfsr_q[0] && (scnt_q != 2'd3);

  // Free-running LFSR x^8+x^6+x^5+x^4+1, seeded at reset
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0],
                 lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // Count consecutive stalls so a fourth one is suppressed
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      scnt_q <= 2'd0;
    end else if (stall) begin
      scnt_q <= scnt_q + 2'd1;
    end else begin
      scnt_q <= 2'd0;
    end
  end
`else
  assign stall = 1'b0;
`endif

  // State, beat counter, latched base address and sticky error
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      err_q   <= err_d;
    end
  end

  // Next-state, RAM control and Moore handshake outputs
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    base_d           = base_q;
    err_d            = err_q;
    ram_we           = 1'b0;
    ram_addr         = beat_addr(base_q, cnt_q);
    o_MEM_Data_Read  = 1'b0;
    o_MEM_Data_Valid = 1'b0;
    o_MEM_Last       = 1'b0;
    o_MEM_Data       = '0;
    o_Busy           = (state_q != ST_IDLE);
    o_Error          = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_MEM_Valid) begin
          base_d  = i_MEM_Address[RAM_ADDR_WIDTH-1:0];
          cnt_d   = '0;
          state_d = (i_MEM_Read_Write_n == WRITE) ?
                    ST_WR_BURST : ST_RD_ADDR;
        end
      end
      ST_WR_BURST: begin
        if (!stall) begin
          ram_we          = 1'b1;
          o_MEM_Data_Read = 1'b1;
          cnt_d           = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            o_MEM_Last = 1'b1;
            state_d    = ST_RECOVER;
          end
        end
      end
      ST_RD_ADDR: begin
        ram_addr = beat_addr(base_q, '0);
        state_d  = ST_RD_BURST;
      end
      ST_RD_BURST: begin
        if (!stall) begin
          o_MEM_Data_Valid = 1'b1;
          o_MEM_Data       = ram_q;
          ram_addr         = beat_addr(base_q, cnt_q + 1'b1);
          cnt_d            = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            o_MEM_Last = 1'b1;
            state_d    = ST_RECOVER;
          end
        end
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_q != ST_IDLE) && (state_q != ST_RECOVER) &&
        !i_MEM_Valid) begin
      err_d = 1'b1;
    end
  end

  mem_sp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (RAM_ADDR_WIDTH)
  ) u_ram (
    .i_Clk  (i_Clk),
    .i_We   (ram_we),
    .i_Addr (ram_addr),
    .i_Data (i_MEM_Data),
    .o_Data (ram_q)
  );

endmodule

// File: tb/tb_mem_burst_responder.sv
// Self-checking bench for mem_burst_responder (default build).
// Per-cycle expectations come from a burst-level memory model.
module tb_mem_burst_responder;

  localparam int DW  = 32;
  localparam int AW  = 22;
  localparam int RAW = 10;
  localparam int L   = 8;
  localparam int N   = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          rw = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;

  logic          o_dr, o_dv, o_last, o_busy, o_err;
  logic [DW-1:0] o_data;

  mem_burst_responder #(
    .DATA_WIDTH     (DW),
    .ADDRESS_WIDTH  (AW),
    .RAM_ADDR_WIDTH (RAW),
    .BURST_LEN      (L)
  ) dut (
    .i_Clk              (clk),
    .i_Reset_n          (rst_n),
    .i_MEM_Valid        (valid),
    .i_MEM_Address      (addr),
    .i_MEM_Read_Write_n (rw),
    .i_MEM_Data         (wdata),
    .o_MEM_Data_Read    (o_dr),
    .o_MEM_Data         (o_data),
    .o_MEM_Data_Valid   (o_dv),
    .o_MEM_Last         (o_last),
    .o_Busy             (o_busy),
    .o_Error            (o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  bit            e_dr   [N];
  bit            e_dv   [N];
  bit            e_last [N];
  bit            e_busy [N];
  bit            e_err  [N];
  logic [DW-1:0] e_d    [N];
  logic [DW-1:0] mem_m  [int];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h",
               nm, cyc, act, req);
    end
  endtask

  function automatic int baddr(input int start, input int k);
    return ((start & ~(L - 1)) | ((start + k) & (L - 1)))
           & ((1 << RAW) - 1);
  endfunction

  task automatic set_busy(input int a, input int b);
    for (int i = a; i <= b; i++) if (i < N) e_busy[i] = 1;
  endtask

  task automatic set_err(input int from);
    for (int i = from; i < N; i++) e_err[i] = 1;
  endtask

  task automatic clear_from(input int from);
    for (int i = from; i < N; i++) begin
      e_dr[i] = 0; e_dv[i] = 0; e_last[i] = 0;
      e_busy[i] = 0; e_err[i] = 0; e_d[i] = '0;
    end
  endtask

  always @(negedge clk) begin
    if (cyc < N) begin
      check("busy", o_busy, e_busy[cyc]);
      check("error", o_err, e_err[cyc]);
      check("data_read", o_dr, e_dr[cyc]);
      check("data_valid", o_dv, e_dv[cyc]);
      check("last", o_last, e_last[cyc]);
      if (e_dv[cyc]) check("rdata", o_data, e_d[cyc]);
      if (!rst_n) check("rst_data", o_data, 32'h0);
    end
  end

  task automatic do_write(input int start, input int base,
                          input bit hold, input int drop,
                          output int c);
    c = cyc;
    valid = 1; rw = 0; addr = AW'(start);
    for (int k = 0; k < L; k++) begin
      e_dr[c + 1 + k] = 1;
      mem_m[baddr(start, k)] = DW'(base + k);
    end
    e_last[c + L] = 1;
    set_busy(c + 1, c + L + 1);
    if (drop >= 0) set_err(c + 2 + drop);
    for (int k = 0; k < L; k++) begin
      @(posedge clk); #1;
      wdata = DW'(base + k);
      valid = (k != drop);
      rw    = 1;
      addr  = ~AW'(start);
    end
    @(posedge clk); #1;
    valid = hold;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input int start, input bit hold,
                         output int c);
    c = cyc;
    valid = 1; rw = 1; addr = AW'(start);
    for (int k = 0; k < L; k++) begin
      e_dv[c + 2 + k] = 1;
      e_d[c + 2 + k]  = mem_m[baddr(start, k)];
    end
    e_last[c + L + 1] = 1;
    set_busy(c + 1, c + L + 2);
    for (int k = 0; k <= L; k++) begin
      @(posedge clk); #1;
      rw   = 0;
      addr = AW'(start + 3);
    end
    @(posedge clk); #1;
    valid = hold;
    @(posedge clk); #1;
  endtask

  initial begin
    int cw, cr, c15, cb, cv, cx;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    do_write(16'h10, 32'h100, 0, -1, cw);
    check("pin_wr_last", e_last[cw + 8], 1);
    check("pin_wr_first", e_dr[cw + 1], 1);

    do_read(16'h10, 0, cr);
    check("pin_rd_b0", e_d[cr + 2], 32'h100);
    check("pin_rd_last", e_last[cr + 9], 1);

    do_read(16'h15, 0, c15);
    check("pin_rd15_b0", e_d[c15 + 2], 32'h105);
    check("pin_rd15_b3", e_d[c15 + 5], 32'h100);
    check("pin_rd15_b7", e_d[c15 + 9], 32'h104);

    do_write(16'h20, 32'h200, 1, -1, cb);
    do_read(16'h23, 0, cx);
    check("pin_b2b_b0", e_d[cx + 2], 32'h203);
    check("pin_b2b_b5", e_d[cx + 7], 32'h200);

    do_write(16'h30, 32'h300, 0, 3, cv);
    check("pin_err", e_err[cv + 5], 1);
    check("pin_err_pre", e_err[cv + 4], 0);
    repeat (3) @(posedge clk);
    #1;

    cx = cyc;
    valid = 1; rw = 1; addr = AW'(16'h10);
    for (int k = 0; k < L; k++) begin
      e_dv[cx + 2 + k] = 1;
      e_d[cx + 2 + k]  = mem_m[baddr(16'h10, k)];
    end
    e_last[cx + L + 1] = 1;
    set_busy(cx + 1, cx + L + 2);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 0;
    valid = 0;
    clear_from(cyc);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    do_read(16'h10, 0, cr);
    check("pin_post_rst_b7", e_d[cr + 9], 32'h107);
    do_read(16'h36, 0, cr);
    check("pin_viol_b5", e_d[cr + 7], 32'h303);

    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_burst_responder.md
# mem_burst_responder

Responder end of the main-memory request interface: accepts one burst transaction at a time from the memory arbiter and serves it from an on-chip synchronous single-port RAM. Exposes the same valid / read-write / data-read / data-valid / last handshake an SDRAM controller presents, so the arbiter, flashloader, IMEM and DMEM paths can run without external SDRAM (bring-up, simulation, small-memory builds). Transactions are fixed-length, address-wrapping bursts.

## Interface
Parameters:
- DATA_WIDTH, 32, word width
- ADDRESS_WIDTH, 22, request address width
- RAM_ADDR_WIDTH, 10, backing store depth = 2^RAM_ADDR_WIDTH words; upper address bits ignored (aliasing)
- BURST_LEN, 8, beats per transaction; power of two, 2..16

Ports:
- i_Clk  in  1  clock
- i_Reset_n  in  1  asynchronous, active-low reset
- i_MEM_Valid  in  1  request valid; held by initiator until Last
- i_MEM_Address  in  ADDRESS_WIDTH  start word address
- i_MEM_Read_Write_n  in  1  1 = read, 0 = write
- i_MEM_Data  in  DATA_WIDTH  write data, current beat
- o_MEM_Data_Read  out  1  write beat consumed this cycle
- o_MEM_Data  out  DATA_WIDTH  read data
- o_MEM_Data_Valid  out  1  read beat valid this cycle
- o_MEM_Last  out  1  final beat of transaction
- o_Busy  out  1  transaction in progress (state != IDLE)
- o_Error  out  1  sticky protocol error, cleared only by reset

## Operation
- States: IDLE, RD_ADDR, RD_BURST, WR_BURST, RECOVER.
- IDLE: on edge with i_MEM_Valid=1, latch address[RAM_ADDR_WIDTH-1:0], direction; beat counter=0; go to WR_BURST (write) or RD_ADDR (read).
- WR_BURST: each beat cycle o_MEM_Data_Read=1; i_MEM_Data written to RAM at that edge; counter+1. Beat BURST_LEN-1 also asserts o_MEM_Last; then RECOVER.
- RD_ADDR: first RAM address presented; go to RD_BURST.
- RD_BURST: each beat o_MEM_Data_Valid=1, o_MEM_Data = RAM word for that beat; Last on beat BURST_LEN-1; then RECOVER.
- Beat address = {start[high bits], (start[low]+beat) mod BURST_LEN}; wraps within aligned BURST_LEN block (critical word first). log2(BURST_LEN) low bits wrap; no carry into upper bits.
- RECOVER: one cycle, all handshake outputs 0, i_MEM_Valid ignored; then IDLE.
- Outputs are Moore (functions of registered state/counters only); no input-to-output combinational path.
- i_MEM_Valid low during WR_BURST/RD_BURST/RD_ADDR: protocol violation; burst still completes with full beat count, o_Error set. Writes during violation still occur.
- Direction/address changes mid-burst ignored (latched values used).
- Reset: State=IDLE, counters 0, o_MEM_Data=0, all 1-bit outputs 0, o_Error=0; effective immediately (async). RAM contents not reset.

## Timing
- Accept edge = E0 (IDLE, valid high).
- Write: beat k in cycle E0+1+k (no stalls); Last in cycle E0+BURST_LEN; IDLE again at E0+BURST_LEN+2.
- Read: RD_ADDR cycle E0+1; beat k in cycle E0+2+k; Last at E0+BURST_LEN+1.
- Min gap between Last and next accept edge: one cycle (RECOVER).
- Throughput: one beat/cycle without stalls.

## Configuration
- MEM_RESPONDER_STALL_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 0xA5 at reset, steps every cycle) inserts stall cycles in WR_BURST/RD_BURST when LFSR bit0=1; stall cycle has Data_Read/Data_Valid/Last=0, counter holds, no RAM write; stall forced off after 3 consecutive stalls. Data order and beat count unchanged.
- Undefined: no LFSR, never stalls; timing exactly as above.

## Structure
- Shared package mem_if_pkg: READ/WRITE constants, responder state encoding, default BURST_LEN.
- Sub-module mem_sp_ram: single-port synchronous RAM, one write port, registered read (1-cycle latency), no reset.

## Test plan
- Write at 0x10, data 0x100..0x107 -> Data_Read high cycles E0+1..E0+8, Last only at E0+8, o_Error=0.
- Read at 0x10 after above -> Data_Valid E0+2..E0+9, data 0x100..0x107, Last at E0+9.
- Read at 0x15 -> data 0x105,0x106,0x107,0x100,0x101,0x102,0x103,0x104 (wrap in block).
- Valid held high across Last -> RECOVER cycle ignores it; accept on following edge; second burst correct.
- Valid dropped at write beat 3 -> 8 Data_Read pulses still issued, Last on 8th, o_Error=1 until reset.
- Reset asserted at read beat 3 -> all outputs 0 same cycle; after release read at 0x10 returns 0x100..0x107 (RAM intact); with MEM_RESPONDER_STALL_EN, same data, exactly 8 beats, ≤3 consecutive stalls.
